// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage / register file slice:
// writeback source codes, default widths and the hard-wired zero register.
package wb_regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int REG_ADDR_W    = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Writeback source select carried down the pipe in reg_src_wb.
    typedef enum logic [1:0] {
        REG_SRC_ALU = 2'b00,
        REG_SRC_MEM = 2'b01,
        REG_SRC_IMM = 2'b10,
        REG_SRC_PC4 = 2'b11
    } reg_src_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_retire_counter.sv
// Free-running retired-instruction counter. Wraps silently at 2^W.
module retire_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count one per enabled cycle; asynchronous clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : retire_counter

// File: rtl/wb_regfile.sv
// Writeback stage consumer: selects the writeback value, commits it to the
// integer register file, serves the two decode read ports (with optional
// same-cycle write-to-read bypass) and counts retired instructions.
// x0 has no storage; it always reads as zero and writes to it are dropped.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int NREGS     = DEFAULT_NREGS,
    parameter int BYPASS_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write_wb,
    input  logic [1:0]            reg_src_wb,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic [XLEN-1:0]       alu_result_wb,
    input  logic [XLEN-1:0]       mem2reg_data_wb,
    input  logic [XLEN-1:0]       imm_wb,
    input  logic [XLEN-1:0]       nxpc_wb,
    input  logic                  retire_wb,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       wb_data,
    output logic [63:0]           instret
);

    // Entry 0 is deliberately absent: x0 is a constant.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic            wr_en;

    // Only writes to an implemented, non-zero register reach storage.
    assign wr_en = reg_write_wb && (rd_wb != REG_ZERO) && (int'(rd_wb) < NREGS);

    // Writeback source mux; stays live during reset for the forwarding unit.
    always_comb begin
        wb_data = alu_result_wb;
        case (reg_src_e'(reg_src_wb))
            REG_SRC_ALU: wb_data = alu_result_wb;
            REG_SRC_MEM: wb_data = mem2reg_data_wb;
            REG_SRC_IMM: wb_data = imm_wb;
            REG_SRC_PC4: wb_data = nxpc_wb;
            default:     wb_data = alu_result_wb;
        endcase
    end

    // Register storage: async clear, one-cycle write commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_wb] <= wb_data;
        end
    end

    // Read port 1: zero for x0 or in reset, else bypass or stored value.
    always_comb begin
        rs1_data = '0;
        if (rst_n && (rs1_addr != REG_ZERO) && (int'(rs1_addr) < NREGS)) begin
            if ((BYPASS_EN != 0) && wr_en && (rd_wb == rs1_addr)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
    end

    // Read port 2: identical rules to port 1.
    always_comb begin
        rs2_data = '0;
        if (rst_n && (rs2_addr != REG_ZERO) && (int'(rs2_addr) < NREGS)) begin
            if ((BYPASS_EN != 0) && wr_en && (rd_wb == rs2_addr)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

    // Retirement is independent of register writes (stores, branches count).
    retire_counter #(
        .W (64)
    ) u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_wb),
        .count (instret)
    );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed steps followed by a randomized phase, both
// checked against a behavioural register-file model. A bypass and a
// non-bypass instance share every input.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write_wb;
    logic [1:0]  reg_src_wb;
    logic [4:0]  rd_wb;
    logic [31:0] alu_result_wb, mem2reg_data_wb, imm_wb, nxpc_wb;
    logic        retire_wb;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic [31:0] nb_rs1_data, nb_rs2_data, nb_wb_data;
    logic [63:0] instret, nb_instret;

    // Reference state
    logic [31:0] m_regs [0:31];
    logic [63:0] m_cnt;
    logic [31:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    // Clock
    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .reg_write_wb(reg_write_wb), .reg_src_wb(reg_src_wb),
        .rd_wb(rd_wb), .alu_result_wb(alu_result_wb), .mem2reg_data_wb(mem2reg_data_wb),
        .imm_wb(imm_wb), .nxpc_wb(nxpc_wb), .retire_wb(retire_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_data(wb_data), .instret(instret)
    );

    wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .reg_write_wb(reg_write_wb), .reg_src_wb(reg_src_wb),
        .rd_wb(rd_wb), .alu_result_wb(alu_result_wb), .mem2reg_data_wb(mem2reg_data_wb),
        .imm_wb(imm_wb), .nxpc_wb(nxpc_wb), .retire_wb(retire_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .wb_data(nb_wb_data), .instret(nb_instret)
    );

    // ---------------- model ----------------
    function automatic logic [31:0] m_wb();
        logic [31:0] v;
        case (reg_src_wb)
            2'd0:    v = alu_result_wb;
            2'd1:    v = mem2reg_data_wb;
            2'd2:    v = imm_wb;
            default: v = nxpc_wb;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (byp && reg_write_wb && rd_wb == a) return m_wb();
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 64'd0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".wb_data"},  64'(wb_data),     64'(m_wb()));
        chk({tag, ".rs1"},      64'(rs1_data),    64'(m_read(rs1_addr, 1'b1)));
        chk({tag, ".rs2"},      64'(rs2_data),    64'(m_read(rs2_addr, 1'b1)));
        chk({tag, ".nb_rs1"},   64'(nb_rs1_data), 64'(m_read(rs1_addr, 1'b0)));
        chk({tag, ".nb_rs2"},   64'(nb_rs2_data), 64'(m_read(rs2_addr, 1'b0)));
        chk({tag, ".instret"},  instret,          m_cnt);
        chk({tag, ".nb_instret"}, nb_instret,     m_cnt);
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        reg_write_wb = 1'b0; reg_src_wb = 2'd0; rd_wb = 5'd0; retire_wb = 1'b0;
        alu_result_wb = '0; mem2reg_data_wb = '0; imm_wb = '0; nxpc_wb = '0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    // Commit the model for the coming edge, then advance to the next negedge.
    task automatic step();
        if (rst_n) begin
            if (reg_write_wb && rd_wb != 5'd0) m_regs[rd_wb] = m_wb();
            if (retire_wb) m_cnt = m_cnt + 64'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_alu(input logic [4:0] rd, input logic [31:0] v, input logic ret);
        reg_write_wb = 1'b1; reg_src_wb = 2'd0; rd_wb = rd; alu_result_wb = v; retire_wb = ret;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] pattern;
        idle();
        rst_n = 1'b0;
        m_clear();
        #2;
        chk("reset.instret", instret, 64'd0);
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        check_all("reset.hold");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Source select, destination x3
        exp_q.push_back(32'h11); exp_q.push_back(32'h22);
        exp_q.push_back(32'h33); exp_q.push_back(32'h44);
        alu_result_wb = 32'h11; mem2reg_data_wb = 32'h22; imm_wb = 32'h33; nxpc_wb = 32'h44;
        reg_write_wb = 1'b1; rd_wb = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            reg_src_wb = 2'(i);
            e = exp_q.pop_front();
            #1;
            chk("srcsel.wb_data", 64'(wb_data), 64'(e));
            check_all("srcsel");
            step();
        end
        reg_write_wb = 1'b0;
        check_all("srcsel.final");
        chk("srcsel.x3", 64'(rs1_data), 64'h44);

        // x0 protection
        idle();
        write_alu(5'd0, 32'hFFFF_FFFF, 1'b0);
        check_all("x0.same");
        chk("x0.rs1", 64'(rs1_data), 64'd0);
        step();
        reg_write_wb = 1'b0;
        check_all("x0.next");
        chk("x0.rs2", 64'(rs2_data), 64'd0);

        // Bypass, both ports on x7
        idle();
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        write_alu(5'd7, 32'h1234_5678, 1'b0);
        step();
        write_alu(5'd7, 32'hCAFE_0001, 1'b0);
        check_all("bypass.same");
        chk("bypass.rs1", 64'(rs1_data), 64'hCAFE_0001);
        chk("bypass.nb_old", 64'(nb_rs2_data), 64'h1234_5678);
        step();
        reg_write_wb = 1'b0;
        check_all("bypass.next");
        chk("bypass.nb_new", 64'(nb_rs1_data), 64'hCAFE_0001);

        // Back-to-back writes to x9
        idle();
        rs2_addr = 5'd9;
        write_alu(5'd9, 32'd1, 1'b1);
        check_all("b2b.c1");
        chk("b2b.c1.rs2", 64'(rs2_data), 64'd1);
        step();
        write_alu(5'd9, 32'd2, 1'b1);
        check_all("b2b.c2");
        chk("b2b.c2.rs2", 64'(rs2_data), 64'd2);
        step();
        reg_write_wb = 1'b0; retire_wb = 1'b0;
        check_all("b2b.c3");
        chk("b2b.c3.rs2", 64'(rs2_data), 64'd2);

        // Reset mid-run after writing x5
        idle();
        write_alu(5'd5, 32'hDEAD_BEEF, 1'b1);
        step();
        idle();
        rs1_addr = 5'd5;
        check_all("midrst.pre");
        chk("midrst.pre.x5", 64'(rs1_data), 64'hDEAD_BEEF);
        rst_n = 1'b0;
        m_clear();
        check_all("midrst.low");
        chk("midrst.low.x5", 64'(rs1_data), 64'd0);
        chk("midrst.low.instret", instret, 64'd0);
        step();
        rst_n = 1'b1;
        check_all("midrst.after");
        chk("midrst.after.x5", 64'(rs1_data), 64'd0);

        // Retire pattern 1101100111 from a zero count
        idle();
        pattern = 10'b1101100111;
        for (int i = 9; i >= 0; i--) begin
            retire_wb = pattern[i];
            step();
        end
        retire_wb = 1'b0;
        check_all("retire.pattern");
        chk("retire.seven", instret, 64'd7);

        // Wrap from all-ones
        force dut.u_retire.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        force dut_nb.u_retire.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_retire.count_q;
        release dut_nb.u_retire.count_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        check_all("wrap.preload");
        retire_wb = 1'b1;
        step();
        retire_wb = 1'b0;
        check_all("wrap.after");
        chk("wrap.zero", instret, 64'd0);

        // Randomized traffic, destinations biased to a few registers
        for (int n = 0; n < 300; n++) begin
            reg_write_wb    = 1'($urandom_range(0, 1));
            reg_src_wb      = 2'($urandom_range(0, 3));
            rd_wb           = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(0, 4));
            rs1_addr        = 5'($urandom_range(0, 5));
            rs2_addr        = ($urandom_range(0, 1) == 0) ? rd_wb : 5'($urandom_range(0, 31));
            alu_result_wb   = $urandom;
            mem2reg_data_wb = $urandom;
            imm_wb          = $urandom;
            nxpc_wb         = $urandom;
            retire_wb       = 1'($urandom_range(0, 1));
            check_all("rand");
            step();
        end
        idle();
        check_all("rand.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_regfile
